dm_hw_allocator: RTL and testbench

- Synthesizable address allocator that services alloc and free requests from RTL initiators.
- Manages a contiguous region of `NUM_UNITS` address units starting at `BASE`.
- Alloc requests carry a size and an alignment; frees carry the start address returned by a previous alloc.
- Sits on the responder side of the allocator request interface and replaces the software allocator model when the allocator must live in hardware.

---
 rtl/dm_hw_allocator_if.sv | 28 ++
 rtl/dm_hw_allocator.sv | 151 +++++++++++++++
 tb/tb_dm_hw_allocator.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dm_hw_allocator_if.sv
// Alloc / response / free request bundle between RTL initiators and the hardware allocator.
interface dm_hw_allocator_if #(
  parameter int ADDR_W = 64,
  parameter int SIZE_W = 4
) ();
  logic              alloc_valid;
  logic              alloc_ready;
  logic [SIZE_W-1:0] alloc_size;
  logic [SIZE_W-1:0] alloc_align;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_ok;
  logic [ADDR_W-1:0] rsp_addr;
  logic              free_valid;
  logic              free_ready;
  logic [ADDR_W-1:0] free_addr;
  logic              free_err;

  modport master (
    output alloc_valid, alloc_size, alloc_align, rsp_ready, free_valid, free_addr,
    input  alloc_ready, rsp_valid, rsp_ok, rsp_addr, free_ready, free_err
  );

  modport slave (
    input  alloc_valid, alloc_size, alloc_align, rsp_ready, free_valid, free_addr,
    output alloc_ready, rsp_valid, rsp_ok, rsp_addr, free_ready, free_err
  );
endinterface

// File: rtl/dm_hw_allocator.sv
// First-fit address allocator over NUM_UNITS units starting at BASE; one candidate
// offset is examined per cycle while an alloc is outstanding.
//
// state  | meaning
// IDLE   | accepting frees (priority) and allocs
// SEARCH | testing candidate offset idx for the latched size/alignment
// RESP   | holding the alloc result until rsp_ready
module dm_hw_allocator #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE      = 1,
  parameter int                NUM_UNITS = 16,
  parameter int                MAX_SIZE  = 8,
  parameter int                SIZE_W    = $clog2(MAX_SIZE) + 1
) (
  input  logic             clock,
  input  logic             resetn,
  dm_hw_allocator_if.slave bus
);
  localparam int UNIT_W = $clog2(NUM_UNITS);
  // Two spare bits: idx + size + align can never wrap.
  localparam int CMP_W  = UNIT_W + 3;
  localparam logic [CMP_W-1:0] UNITS_C = CMP_W'(NUM_UNITS);

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_e;

  state_e                           state_q, state_d;
  logic [NUM_UNITS-1:0]             used_q, used_d;
  logic [NUM_UNITS-1:0]             start_q, start_d;
  logic [NUM_UNITS-1:0][SIZE_W-1:0] len_q, len_d;
  logic [SIZE_W-1:0]                size_q, size_d;
  logic [SIZE_W-1:0]                align_q, align_d;
  logic [CMP_W-1:0]                 idx_q, idx_d;
  logic                             rsp_ok_q, rsp_ok_d;
  logic [ADDR_W-1:0]                rsp_addr_q, rsp_addr_d;
  logic                             free_bad_q, free_bad_d;
  logic                             free_err_q, free_err_d;

  logic [ADDR_W-1:0]    free_off;
  logic [UNIT_W-1:0]    free_idx;
  logic                 free_hit;
  logic [CMP_W-1:0]     free_end, cand_end, next_end;
  logic [NUM_UNITS-1:0] free_mask, fit_mask;
  logic                 size_ok, fits;

  always_comb begin
    free_off  = bus.free_addr - BASE;
    free_idx  = free_off[UNIT_W-1:0];
    free_hit  = (bus.free_addr >= BASE) && (free_off < ADDR_W'(NUM_UNITS)) && start_q[free_idx];
    free_end  = CMP_W'(free_idx) + CMP_W'(len_q[free_idx]);
    cand_end  = idx_q + CMP_W'(size_q);
    next_end  = cand_end + CMP_W'(align_q);
    size_ok   = (size_q != '0) && (size_q <= SIZE_W'(MAX_SIZE));
    free_mask = '0;
    fit_mask  = '0;
    for (int j = 0; j < NUM_UNITS; j++) begin
      free_mask[j] = (CMP_W'(j) >= CMP_W'(free_idx)) && (CMP_W'(j) < free_end);
      fit_mask[j]  = (CMP_W'(j) >= idx_q) && (CMP_W'(j) < cand_end);
    end
    fits = size_ok && (cand_end <= UNITS_C) && ((used_q & fit_mask) == '0);
  end

  always_comb begin
    state_d         = state_q;
    used_d          = used_q;
    start_d         = start_q;
    len_d           = len_q;
    size_d          = size_q;
    align_d         = align_q;
    idx_d           = idx_q;
    rsp_ok_d        = rsp_ok_q;
    rsp_addr_d      = rsp_addr_q;
    free_bad_d      = 1'b0;
    free_err_d      = free_bad_q;
    bus.alloc_ready = 1'b0;
    bus.free_ready  = 1'b0;
    bus.rsp_valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.free_ready  = 1'b1;
        bus.alloc_ready = !bus.free_valid;
        if (bus.free_valid) begin
          if (free_hit) begin
            used_d            = used_q & ~free_mask;
            start_d[free_idx] = 1'b0;
          end else begin
            free_bad_d = 1'b1;
          end
        end else if (bus.alloc_valid) begin
          // Bad sizes also pass through SEARCH, which fails them on its first cycle.
          size_d  = bus.alloc_size;
          align_d = (bus.alloc_align == '0) ? SIZE_W'(1) : bus.alloc_align;
          idx_d   = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (fits) begin
          used_d                    = used_q | fit_mask;
          start_d[idx_q[UNIT_W-1:0]] = 1'b1;
          len_d[idx_q[UNIT_W-1:0]]   = size_q;
          rsp_ok_d                  = 1'b1;
          rsp_addr_d                = BASE + ADDR_W'(idx_q);
          state_d                   = RESP;
        end else if (size_ok && (next_end <= UNITS_C)) begin
          idx_d = idx_q + CMP_W'(align_q);
        end else begin
          rsp_ok_d   = 1'b0;
          rsp_addr_d = '0;
          state_d    = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      used_q     <= '0;
      start_q    <= '0;
      len_q      <= '0;
      size_q     <= '0;
      align_q    <= '0;
      idx_q      <= '0;
      rsp_ok_q   <= 1'b0;
      rsp_addr_q <= '0;
      free_bad_q <= 1'b0;
      free_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      used_q     <= used_d;
      start_q    <= start_d;
      len_q      <= len_d;
      size_q     <= size_d;
      align_q    <= align_d;
      idx_q      <= idx_d;
      rsp_ok_q   <= rsp_ok_d;
      rsp_addr_q <= rsp_addr_d;
      free_bad_q <= free_bad_d;
      free_err_q <= free_err_d;
    end
  end

  assign bus.rsp_ok   = rsp_ok_q;
  assign bus.rsp_addr = rsp_addr_q;
  assign bus.free_err = free_err_q;
endmodule

// File: tb/tb_dm_hw_allocator.sv
// Directed, table-driven bench for dm_hw_allocator plus hand-written handshake/reset sequences.
module tb_dm_hw_allocator;
  typedef enum logic {OP_ALLOC, OP_FREE} op_e;
  typedef struct {
    op_e         op;
    logic [3:0]  size;
    logic [3:0]  align;
    logic [63:0] addr;
    logic        exp_ok;
    logic [63:0] exp_addr;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  logic clock;
  logic resetn;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  dm_hw_allocator_if #(.ADDR_W(64), .SIZE_W(4)) bif ();

  dm_hw_allocator #(
    .ADDR_W(64), .BASE(64'd1), .NUM_UNITS(16), .MAX_SIZE(8), .SIZE_W(4)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add_alloc(input logic [3:0] sz, input logic [3:0] al,
                                    input logic ok, input logic [63:0] addr, input int lat);
    vecs.push_back('{OP_ALLOC, sz, al, 64'd0, ok, addr, lat, 1'b0});
  endfunction

  function automatic void add_free(input logic [63:0] addr, input logic err);
    vecs.push_back('{OP_FREE, 4'd0, 4'd0, addr, 1'b0, 64'd0, 0, err});
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  // Starts #1 after a rising edge with the DUT idle; returns #1 after the response handshake.
  task automatic do_alloc(input logic [3:0] sz, input logic [3:0] al,
                          output logic ok, output logic [63:0] addr, output int lat);
    bif.alloc_valid = 1'b1;
    bif.alloc_size  = sz;
    bif.alloc_align = al;
    @(posedge clock);
    #1 bif.alloc_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clock);
      #1 lat++;
    end while (!bif.rsp_valid && lat < 64);
    check("alloc rsp_valid seen", {63'd0, bif.rsp_valid}, 64'd1);
    ok   = bif.rsp_ok;
    addr = bif.rsp_addr;
    @(posedge clock);
    #1;
  endtask

  // Returns free_err sampled after the accept edge and the two edges after it.
  task automatic do_free(input logic [63:0] addr, output logic [2:0] pulse);
    bif.free_valid = 1'b1;
    bif.free_addr  = addr;
    @(posedge clock);
    #1 bif.free_valid = 1'b0;
    pulse[2] = bif.free_err;
    @(posedge clock);
    #1 pulse[1] = bif.free_err;
    @(posedge clock);
    #1 pulse[0] = bif.free_err;
  endtask

  initial begin
    logic        ok;
    logic [63:0] addr;
    int          lat;
    logic [2:0]  pulse;

    // First fit, reuse after free
    for (int k = 1; k <= 8; k++) add_alloc(4'd1, 4'd1, 1'b1, 64'(k), k);
    for (int k = 1; k <= 8; k++) add_free(64'(k), 1'b0);
    add_alloc(4'd1, 4'd1, 1'b1, 64'd1, 1);
    add_free(64'd1, 1'b0);
    // Exhaustion and bad sizes
    for (int k = 1; k <= 16; k++) add_alloc(4'd1, 4'd1, 1'b1, 64'(k), k);
    add_alloc(4'd1, 4'd1, 1'b0, 64'd0, 16);
    add_alloc(4'd9, 4'd1, 1'b0, 64'd0, 1);
    add_alloc(4'd0, 4'd1, 1'b0, 64'd0, 1);
    for (int k = 1; k <= 16; k++) add_free(64'(k), 1'b0);
    // Alignment and bad frees
    add_alloc(4'd1, 4'd1, 1'b1, 64'd1, 1);
    add_alloc(4'd4, 4'd4, 1'b1, 64'd5, 2);
    add_alloc(4'd2, 4'd2, 1'b1, 64'd3, 2);
    add_free(64'd5, 1'b0);
    add_alloc(4'd4, 4'd4, 1'b1, 64'd5, 2);
    add_free(64'd6, 1'b1);
    add_alloc(4'd4, 4'd4, 1'b1, 64'd9, 3);
    add_free(64'd9, 1'b0);
    add_alloc(4'd1, 4'd0, 1'b1, 64'd2, 2);
    add_free(64'd5, 1'b0);
    add_free(64'd5, 1'b1);
    add_free(64'd0, 1'b1);
    add_free(64'd17, 1'b1);
    add_free(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    add_free(64'd3, 1'b0);
    add_free(64'd4, 1'b1);

    bif.alloc_valid = 1'b0;
    bif.alloc_size  = '0;
    bif.alloc_align = '0;
    bif.rsp_ready   = 1'b1;
    bif.free_valid  = 1'b0;
    bif.free_addr   = '0;
    resetn          = 1'b0;
    do_reset();

    check("reset rsp_valid",   {63'd0, bif.rsp_valid},   64'd0);
    check("reset rsp_ok",      {63'd0, bif.rsp_ok},      64'd0);
    check("reset rsp_addr",    bif.rsp_addr,             64'd0);
    check("reset free_err",    {63'd0, bif.free_err},    64'd0);
    check("reset alloc_ready", {63'd0, bif.alloc_ready}, 64'd1);
    check("reset free_ready",  {63'd0, bif.free_ready},  64'd1);

    foreach (vecs[i]) begin
      if (vecs[i].op == OP_ALLOC) begin
        do_alloc(vecs[i].size, vecs[i].align, ok, addr, lat);
        check($sformatf("v%0d alloc ok", i),   {63'd0, ok}, {63'd0, vecs[i].exp_ok});
        check($sformatf("v%0d alloc addr", i), addr, vecs[i].exp_addr);
        check($sformatf("v%0d alloc latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      end else begin
        do_free(vecs[i].addr, pulse);
        check($sformatf("v%0d free_err pulse", i), {61'd0, pulse}, {61'd0, 1'b0, vecs[i].exp_err, 1'b0});
      end
    end

    // Free wins over a simultaneous alloc; then a stalled response
    do_reset();
    bif.alloc_valid = 1'b1;
    bif.alloc_size  = 4'd1;
    bif.alloc_align = 4'd1;
    bif.free_valid  = 1'b1;
    bif.free_addr   = 64'd1;
    #1;
    check("prio alloc_ready", {63'd0, bif.alloc_ready}, 64'd0);
    check("prio free_ready",  {63'd0, bif.free_ready},  64'd1);
    @(posedge clock);
    #1 bif.free_valid = 1'b0;
    #1;
    check("prio alloc_ready after free", {63'd0, bif.alloc_ready}, 64'd1);
    @(posedge clock);
    #1 bif.alloc_valid = 1'b0;
    bif.rsp_ready = 1'b0;
    check("prio free_err",           {63'd0, bif.free_err},    64'd1);
    check("prio alloc_ready search", {63'd0, bif.alloc_ready}, 64'd0);
    @(posedge clock);
    #1;
    check("stall rsp_valid", {63'd0, bif.rsp_valid}, 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      check($sformatf("stall%0d rsp_valid", c),   {63'd0, bif.rsp_valid},   64'd1);
      check($sformatf("stall%0d rsp_ok", c),      {63'd0, bif.rsp_ok},      64'd1);
      check($sformatf("stall%0d rsp_addr", c),    bif.rsp_addr,             64'd1);
      check($sformatf("stall%0d alloc_ready", c), {63'd0, bif.alloc_ready}, 64'd0);
      check($sformatf("stall%0d free_ready", c),  {63'd0, bif.free_ready},  64'd0);
    end
    bif.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    check("stall release rsp_valid",   {63'd0, bif.rsp_valid},   64'd0);
    check("stall release alloc_ready", {63'd0, bif.alloc_ready}, 64'd1);

    // Reset in the middle of a long failing search
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      do_alloc(4'd1, 4'd1, ok, addr, lat);
      check($sformatf("fill%0d addr", k), addr, 64'(k));
    end
    bif.alloc_valid = 1'b1;
    bif.alloc_size  = 4'd1;
    bif.alloc_align = 4'd1;
    @(posedge clock);
    #1 bif.alloc_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("mid-search rsp_valid", {63'd0, bif.rsp_valid}, 64'd0);
    resetn = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    check("abort rsp_valid",   {63'd0, bif.rsp_valid},   64'd0);
    check("abort alloc_ready", {63'd0, bif.alloc_ready}, 64'd1);
    do_free(64'd2, pulse);
    check("abort free cleared block", {61'd0, pulse}, 64'd2);
    do_alloc(4'd1, 4'd1, ok, addr, lat);
    check("abort realloc ok",      {63'd0, ok}, 64'd1);
    check("abort realloc addr",    addr,        64'd1);
    check("abort realloc latency", 64'(lat),    64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
